uvme_cvmcu_obi_trk: RTL and testbench
=====================================

# uvme_cvmcu_obi_trk

Passive OBI transaction tracker for the CORE-V MCU instruction port. It sits directly upstream of the `uvme_cvmcu` assertion checker.
- Snoops the raw OBI A/R channel signals and pairs each grant with its response.
- Produces per-transaction completion records and one-cycle protocol-error pulses.
- The checker and the probe interface consume these outputs to judge `obi_instr_if` behaviour.
- It never drives the bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, OBI address width.
- `MAX_OUTST`, 4, maximum outstanding granted transactions (power of 2, ≥2).
- `LAT_WIDTH`, 16, width of cycle counter and latency output.
- `TIMEOUT`, 1024, cycles a head transaction may wait for `rvalid` (< 2^LAT_WIDTH).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  sampling clock.
  - `reset`  in  1  asynchronous, active-high reset.
- Snooped OBI signals:
  - `req`  in  1  OBI address-phase request.
  - `gnt`  in  1  OBI grant.
  - `addr`  in  ADDR_WIDTH  request address.
  - `we`  in  1  write enable.
  - `rvalid`  in  1  response valid.
  - `err`  in  1  response error.
- Outputs:
  - `outst_cnt`  out  $clog2(MAX_OUTST)+1  granted-but-unanswered count.
  - `done`  out  1  one-cycle completion pulse.
  - `done_addr`  out  ADDR_WIDTH  address of completed transaction.
  - `done_we`  out  1  `we` of completed transaction.
  - `done_err`  out  1  `err` of completed transaction.
  - `done_lat`  out  LAT_WIDTH  grant-to-response latency in cycles.
  - `err_req_drop`  out  1  `req` deasserted before `gnt`.
  - `err_unstable`  out  1  `addr` or `we` changed while waiting for `gnt`.
  - `err_spurious`  out  1  `rvalid` with nothing outstanding.
  - `err_overflow`  out  1  grant accepted while tracker is full.
  - `err_timeout`  out  1  head transaction exceeded `TIMEOUT`.

## Operation
- Address-phase FSM:
  - States `IDLE` and `WAIT_GNT`.
  - `IDLE`: `req & ~gnt` → latch `addr`/`we`, go to `WAIT_GNT`. `req & gnt` → accept, stay in `IDLE`.
  - `WAIT_GNT`: `~req` → pulse `err_req_drop`, go to `IDLE`.
  - `WAIT_GNT`: `req` with `addr`/`we` ≠ latched values → pulse `err_unstable` (once per change cycle).
  - `WAIT_GNT`: `req & gnt` → accept, go to `IDLE`.
- Accept: push {addr, we, timestamp} into the FIFO. The timestamp is the free-running LAT_WIDTH counter `now`.
- Response: `rvalid` pops the head, then drives `done*` with `done_lat = now - head.ts` (modulo 2^LAT_WIDTH).
- `rvalid` while FIFO empty → `err_spurious`, no pop.
  - A response in the same cycle as its own grant counts as spurious when the FIFO was empty before that cycle.
- Accept with count==MAX_OUTST and no same-cycle `rvalid` → `err_overflow`, push dropped.
- Full + accept + `rvalid` in the same cycle → pop then push, count unchanged, no error.
- Timeout: head-age counter resets on pop or on a new head. It saturates at `TIMEOUT`; `err_timeout` pulses exactly once when the counter reaches `TIMEOUT`.
- `now` wraps naturally; latencies are correct below 2^LAT_WIDTH.

## Timing
- All outputs are registered.
  - `done*` and all `err_*` appear one cycle after the triggering edge.
  - `outst_cnt` reflects pushes/pops one cycle after the edge.
- Reset values:
  - all outputs 0;
  - FSM in `IDLE`;
  - FIFO empty;
  - `now` = 0;
  - age counter = 0.
- Reset mid-transaction discards all outstanding entries. No `done`, `err_timeout` or `err_spurious` is raised for them; post-reset `rvalid` for them is reported as spurious.
- `done_*` data fields hold their last value while `done`=0.

## Structure
- Package `uvme_cvmcu_obi_trk_pkg` holds:
  - `uvme_cvmcu_obi_trk_state_t` (`IDLE`, `WAIT_GNT`);
  - the FIFO entry struct `uvme_cvmcu_obi_trk_entry_t` {addr, we, ts};
  - the default-parameter localparams.
- Sub-module `uvme_cvmcu_obi_trk_fifo`:
  - MAX_OUTST-deep register FIFO with push/pop/count;
  - pop-before-push semantics when full.

## Test plan
- Single read: req=gnt=1 at addr 0x1C00_0000 at cycle 0, rvalid at cycle 3 → `done`=1, `done_addr`=0x1C00_0000, `done_lat`=3, `outst_cnt` back to 0.
- Pipelined reads: 4 back-to-back grants at 0x0,0x4,0x8,0xC, responses at cycles 5..8 → `done_addr` in order, latencies 5,5,5,5, no error pulses.
- Full boundary: 4 grants outstanding.
  - 5th grant alone → `err_overflow`=1, `outst_cnt`=4.
  - 5th grant with simultaneous rvalid → no error, `outst_cnt`=4.
- Phase violations:
  - req held 2 cycles without gnt, then dropped → `err_req_drop` once.
  - addr changed 0x10→0x14 during wait → `err_unstable`.
- Spurious and timeout: TIMEOUT=8.
  - rvalid with empty FIFO → `err_spurious`.
  - A grant with no response → `err_timeout` once, 8 cycles after the grant.
- Reset mid-flight: 2 outstanding, assert reset, then rvalid → all outputs 0 during reset; post-reset rvalid raises `err_spurious`, no `done`.

Source files
------------

// File: rtl/uvme_cvmcu_obi_trk_pkg.sv
// uvme_cvmcu_obi_trk_pkg: shared types and default parameters for the OBI transaction tracker.
package uvme_cvmcu_obi_trk_pkg;
    localparam int TRK_ADDR_WIDTH = 32;
    localparam int TRK_MAX_OUTST  = 4;
    localparam int TRK_LAT_WIDTH  = 16;
    localparam int TRK_TIMEOUT    = 1024;

    typedef enum logic {IDLE, WAIT_GNT} uvme_cvmcu_obi_trk_state_t;

    // Entry fields are sized by the package widths; the tracker's ADDR_WIDTH/LAT_WIDTH must not exceed them.
    typedef struct packed {
        logic [TRK_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [TRK_LAT_WIDTH-1:0]  ts;
    } uvme_cvmcu_obi_trk_entry_t;
endpackage

// File: rtl/uvme_cvmcu_obi_trk_fifo.sv
// uvme_cvmcu_obi_trk_fifo: register FIFO of granted transactions; a pop frees the slot a same-cycle push uses.
module uvme_cvmcu_obi_trk_fifo
    import uvme_cvmcu_obi_trk_pkg::*;
#(
    parameter int DEPTH = TRK_MAX_OUTST
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  uvme_cvmcu_obi_trk_entry_t        wdata,
    output uvme_cvmcu_obi_trk_entry_t        head,
    output logic [$clog2(DEPTH):0]           count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    uvme_cvmcu_obi_trk_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = pop & (r_cnt != '0);
    assign w_push = push & ((r_cnt != CW'(DEPTH)) | w_pop);
    assign head   = r_mem[r_rp];
    assign count  = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/uvme_cvmcu_obi_trk.sv
// uvme_cvmcu_obi_trk: passive OBI tracker pairing grants with responses and flagging protocol errors.
module uvme_cvmcu_obi_trk
    import uvme_cvmcu_obi_trk_pkg::*;
#(
    parameter int ADDR_WIDTH = TRK_ADDR_WIDTH,
    parameter int MAX_OUTST  = TRK_MAX_OUTST,
    parameter int LAT_WIDTH  = TRK_LAT_WIDTH,
    parameter int TIMEOUT    = TRK_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req,
    input  logic                           gnt,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           we,
    input  logic                           rvalid,
    input  logic                           err,
    output logic [$clog2(MAX_OUTST):0]     outst_cnt,
    output logic                           done,
    output logic [ADDR_WIDTH-1:0]          done_addr,
    output logic                           done_we,
    output logic                           done_err,
    output logic [LAT_WIDTH-1:0]           done_lat,
    output logic                           err_req_drop,
    output logic                           err_unstable,
    output logic                           err_spurious,
    output logic                           err_overflow,
    output logic                           err_timeout
);
    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam logic [LAT_WIDTH-1:0] TO = LAT_WIDTH'(TIMEOUT);

    uvme_cvmcu_obi_trk_state_t r_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_we;
    logic [LAT_WIDTH-1:0]      r_now;
    logic [LAT_WIDTH-1:0]      r_age;
    logic [CW-1:0]             w_cnt;
    uvme_cvmcu_obi_trk_entry_t w_head;
    uvme_cvmcu_obi_trk_entry_t w_entry;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_age_hit;

    assign w_empty   = w_cnt == '0;
    assign w_full    = w_cnt == CW'(MAX_OUTST);
    assign w_pop     = rvalid & ~w_empty;
    assign w_push    = req & gnt & (~w_full | rvalid);
    assign w_entry   = '{addr: TRK_ADDR_WIDTH'(addr), we: we, ts: TRK_LAT_WIDTH'(r_now)};
    assign w_age_hit = ~w_empty & ~w_pop & (r_age == TO - 1'b1);
    assign outst_cnt = w_cnt;

    uvme_cvmcu_obi_trk_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_entry),
        .head  (w_head),
        .count (w_cnt)
    );

    // Age restarts whenever the head changes (pop) or the FIFO is empty, and saturates at TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_now       <= '0;
            r_age       <= '0;
            err_timeout <= 1'b0;
        end else begin
            r_now       <= r_now + 1'b1;
            r_age       <= (w_empty | w_pop) ? '0 : (r_age == TO) ? TO : r_age + 1'b1;
            err_timeout <= w_age_hit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done         <= 1'b0;
            done_addr    <= '0;
            done_we      <= 1'b0;
            done_err     <= 1'b0;
            done_lat     <= '0;
            err_spurious <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            done         <= w_pop;
            err_spurious <= rvalid & w_empty;
            err_overflow <= req & gnt & w_full & ~rvalid;
            if (w_pop) begin
                done_addr <= ADDR_WIDTH'(w_head.addr);
                done_we   <= w_head.we;
                done_err  <= err;
                done_lat  <= r_now - LAT_WIDTH'(w_head.ts);
            end
        end
    end

    // The latch follows every change so each new value flags err_unstable only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_we         <= 1'b0;
            err_req_drop <= 1'b0;
            err_unstable <= 1'b0;
        end else begin
            err_req_drop <= 1'b0;
            err_unstable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req & ~gnt) begin
                        r_addr  <= addr;
                        r_we    <= we;
                        r_state <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (~req) begin
                        err_req_drop <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        err_unstable <= (addr != r_addr) | (we != r_we);
                        r_addr       <= addr;
                        r_we         <= we;
                        if (gnt) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uvme_cvmcu_obi_trk.sv
// tb_uvme_cvmcu_obi_trk: scoreboard bench for the OBI tracker with TIMEOUT=8.
module tb_uvme_cvmcu_obi_trk;
    localparam int TO = 8;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, gnt = 1'b0, we = 1'b0, rvalid = 1'b0, err = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  outst_cnt;
    logic        done, done_we, done_err;
    logic [31:0] done_addr;
    logic [15:0] done_lat;
    logic        err_req_drop, err_unstable, err_spurious, err_overflow, err_timeout;

    uvme_cvmcu_obi_trk #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .addr(addr), .we(we),
        .rvalid(rvalid), .err(err), .outst_cnt(outst_cnt), .done(done),
        .done_addr(done_addr), .done_we(done_we), .done_err(done_err), .done_lat(done_lat),
        .err_req_drop(err_req_drop), .err_unstable(err_unstable), .err_spurious(err_spurious),
        .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        w;
        int          t;
    } rec_t;

    rec_t sq[$];
    int   checks = 0;
    int   fails = 0;
    int   tnow = 0;
    int   age = 0;
    logic ph = 1'b0;
    logic [31:0] la = '0;
    logic        lw = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rq, input logic g, input logic [31:0] a, input logic w,
                       input logic rv, input logic e);
        int   n;
        logic x_spur, x_pop, x_ovf, x_drop, x_unst, x_to, x_err;
        int   x_rsp;
        rec_t r;
        logic [15:0] lat;
        req = rq; gnt = g; addr = a; we = w; rvalid = rv; err = e;
        n      = sq.size();
        x_spur = rv && n == 0;
        x_pop  = rv && n != 0;
        x_ovf  = rq && g && n == MO && !rv;
        x_err  = e;
        x_rsp  = tnow;
        if (rq && g && !x_ovf) sq.push_back('{a: a, w: w, t: tnow});
        x_drop = ph && !rq;
        x_unst = ph && rq && (a != la || w != lw);
        if (rq) begin
            la = a;
            lw = w;
        end
        ph   = rq && !g;
        x_to = n != 0 && !x_pop && age == TO - 1;
        age  = (n == 0 || x_pop) ? 0 : (age == TO ? TO : age + 1);
        @(posedge clk);
        #1;
        tnow++;
        chk("done", done, x_pop);
        if (x_pop) begin
            r   = sq.pop_front();
            lat = 16'(x_rsp - r.t);
            chk("done_addr", done_addr, r.a);
            chk("done_we", done_we, r.w);
            chk("done_err", done_err, x_err);
            chk("done_lat", done_lat, lat);
        end
        chk("outst_cnt", outst_cnt, sq.size());
        chk("err_spurious", err_spurious, x_spur);
        chk("err_overflow", err_overflow, x_ovf);
        chk("err_req_drop", err_req_drop, x_drop);
        chk("err_unstable", err_unstable, x_unst);
        chk("err_timeout", err_timeout, x_to);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rsp(input logic e);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cnt"}, outst_cnt, 0);
        chk({tag, "_done"}, {done, done_we, done_err}, 0);
        chk({tag, "_daddr"}, done_addr, 0);
        chk({tag, "_dlat"}, done_lat, 0);
        chk({tag, "_errs"}, {err_req_drop, err_unstable, err_spurious, err_overflow, err_timeout}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Single read, response three cycles after the grant
        cyc(1'b1, 1'b1, 32'h1C00_0000, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        rsp(1'b0);
        chk("single_done", done, 1);
        chk("single_addr", done_addr, 32'h1C00_0000);
        chk("single_lat", done_lat, 3);
        chk("single_cnt", outst_cnt, 0);
        idle();
        chk("hold_addr", done_addr, 32'h1C00_0000);
        chk("hold_lat", done_lat, 3);

        // Pipelined grants with latency 5 each
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'(i * 4), i == 2, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) begin
            rsp(i == 2);
            chk("pipe_addr", done_addr, 32'(i * 4));
            chk("pipe_lat", done_lat, 5);
        end

        // Full boundary
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_cnt", outst_cnt, 4);
        cyc(1'b1, 1'b1, 32'h204, 1'b1, 1'b1, 1'b0);
        chk("full_swap_flag", err_overflow, 0);
        chk("full_swap_cnt", outst_cnt, 4);
        chk("full_swap_addr", done_addr, 32'h100);
        repeat (4) rsp(1'b0);
        chk("full_last_addr", done_addr, 32'h204);
        chk("full_drained", outst_cnt, 0);

        // Phase violations
        cyc(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0);
        idle();
        chk("req_drop", err_req_drop, 1);
        idle();
        cyc(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h14, 1'b0, 1'b0, 1'b0);
        chk("unstable", err_unstable, 1);
        cyc(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
        chk("unstable_once", err_unstable, 0);
        rsp(1'b0);
        chk("phase_addr", done_addr, 32'h14);

        // Spurious response and timeout
        rsp(1'b0);
        chk("spurious", err_spurious, 1);
        chk("spurious_nodone", done, 0);
        cyc(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        repeat (7) idle();
        chk("timeout_early", err_timeout, 0);
        idle();
        chk("timeout8", err_timeout, 1);
        repeat (3) idle();
        rsp(1'b0);
        chk("timeout_lat", done_lat, 12);

        // Reset with two transactions in flight
        cyc(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_cnt", outst_cnt, 2);
        req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        reset = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_held");
        sq.delete();
        age = 0;
        ph = 1'b0;
        reset = 1'b0;
        rsp(1'b0);
        chk("rst_spurious", err_spurious, 1);
        chk("rst_nodone", done, 0);
        rsp(1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
